// File: rtl/ysyx_24110015_mem2axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24110015_mem2axi_pkg
// Purpose  : Shared definitions for the CPU-memory to AXI4-Lite bridge:
//            FSM state encoding, AXI response codes and a response decoder.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_24110015_mem2axi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Anything other than OKAY is reported to the CPU as an error,
    // including EXOKAY, which this initiator never requests.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY:   err = 1'b0;
            RESP_EXOKAY: err = 1'b1;
            RESP_SLVERR: err = 1'b1;
            RESP_DECERR: err = 1'b1;
            default:     err = 1'b1;
        endcase
        return err;
    endfunction

endpackage : ysyx_24110015_mem2axi_pkg
`default_nettype wire

// File: rtl/ysyx_24110015_mem2axi.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24110015_mem2axi
// Purpose  : Single-outstanding AXI4-Lite initiator. Converts a simple CPU
//            valid/ready request/response interface into AR/R or AW/W/B
//            transactions.
// Ports    : clk, rst (async, active-high)
//            CPU request : req_valid/req_ready, req_wen, req_addr,
//                          req_wdata, req_wstrb
//            CPU response: rsp_valid/rsp_ready, rsp_rdata, rsp_err
//            AXI AR/R    : araddr, arvalid, arready, rdata, rresp, rvalid,
//                          rready
//            AXI AW/W/B  : awaddr, awvalid, awready, wdata, wstrb, wvalid,
//                          wready, bresp, bvalid, bready
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24110015_mem2axi
    import ysyx_24110015_mem2axi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    // CPU request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    // CPU response
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // AXI read address
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_t      r_state;
    logic [31:0] r_addr;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_aw_fin;
    logic        w_w_fin;

    // One latched address serves both AR and AW; only one is ever valid.
    assign araddr   = r_addr;
    assign awaddr   = r_addr;

    assign w_aw_hs  = awvalid & awready;
    assign w_w_hs   = wvalid & wready;
    // A channel is finished if it completed earlier or completes now.
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done  | w_w_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            req_ready <= 1'b1;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            r_addr    <= 32'd0;
            wdata     <= 32'd0;
            wstrb     <= 4'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        r_addr    <= req_addr;
                        wdata     <= req_wdata;
                        wstrb     <= req_wstrb;
                        req_ready <= 1'b0;
                        if (req_wen) begin
                            r_state   <= WR_REQ;
                            awvalid   <= 1'b1;
                            wvalid    <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end else begin
                            r_state <= RD_ADDR;
                            arvalid <= 1'b1;
                        end
                    end
                end

                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_rdata <= rdata;
                        rsp_err   <= resp_is_err(rresp);
                        rsp_valid <= 1'b1;
                        r_state   <= RSP;
                    end
                end

                WR_REQ: begin
                    if (w_aw_hs) begin
                        awvalid   <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        wvalid   <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    // Leave as soon as the later of the two handshakes lands.
                    if (w_aw_fin && w_w_fin) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        bready    <= 1'b1;
                        r_state   <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= resp_is_err(bresp);
                        rsp_valid <= 1'b1;
                        r_state   <= RSP;
                    end
                end

                RSP: begin
                    // req_ready rises one cycle after the response handshake,
                    // so a new request can never overlap it.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    req_ready <= 1'b1;
                    arvalid   <= 1'b0;
                    rready    <= 1'b0;
                    awvalid   <= 1'b0;
                    wvalid    <= 1'b0;
                    bready    <= 1'b0;
                    rsp_valid <= 1'b0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule : ysyx_24110015_mem2axi
`default_nettype wire

// File: tb/tb_ysyx_24110015_mem2axi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24110015_mem2axi
// Purpose  : Self-checking bench for the mem2axi bridge. A transaction-level
//            model tracks which handshakes have happened and predicts every
//            DUT output each cycle; a memory-backed AXI slave answers random
//            traffic with random stalls and response codes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24110015_mem2axi;
    import ysyx_24110015_mem2axi_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    ysyx_24110015_mem2axi dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one transaction in flight, progress tracked by the
    // set of handshakes already observed.
    // ------------------------------------------------------------------
    bit          busy, is_wr, ar_seen, r_seen, aw_seen, w_seen, b_seen;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    bit          rand_mode = 1'b0;
    logic [31:0] dir_rdata = 32'd0;
    logic        dir_err   = 1'b0;
    int          n_done    = 0;
    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];

    // Environment address map: addr[7:6] selects behaviour.
    //   reads : 0,2 OKAY; 1 EXOKAY (mem data); 3 DECERR (tagged data)
    //   writes: 0,1 OKAY (written); 2 SLVERR, 3 DECERR (not written)
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) res[8*b +: 8] = d[8*b +: 8];
        return res;
    endfunction

    task automatic predict(input logic wen, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] region;
        region = a[7:6];
        if (!wen) begin
            exp_err   = (region == 2'd1) || (region == 2'd3);
            exp_rdata = (region == 2'd3) ? (32'hBADD_0000 ^ a) : ref_mem[a[5:2]];
        end else begin
            exp_err   = region[1];
            exp_rdata = 32'd0;
            if (!region[1]) ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst) begin
                check1("rst_valids", arvalid | rready | awvalid | wvalid | bready | rsp_valid | rsp_err, 1'b0);
                check32("rst_data", rsp_rdata | araddr | awaddr | wdata | {28'd0, wstrb}, 32'd0);
                busy = 1'b0;
            end else begin
                check1("m_req_ready", req_ready, !busy);
                check1("m_arvalid", arvalid, busy && !is_wr && !ar_seen);
                if (arvalid) check32("m_araddr", araddr, m_addr);
                check1("m_rready", rready, busy && !is_wr && ar_seen && !r_seen);
                check1("m_awvalid", awvalid, busy && is_wr && !aw_seen);
                if (awvalid) check32("m_awaddr", awaddr, m_addr);
                check1("m_wvalid", wvalid, busy && is_wr && !w_seen);
                if (wvalid) begin
                    check32("m_wdata", wdata, m_wdata);
                    check32("m_wstrb", {28'd0, wstrb}, {28'd0, m_wstrb});
                end
                check1("m_bready", bready, busy && is_wr && aw_seen && w_seen && !b_seen);
                check1("m_rsp_valid", rsp_valid, busy && (r_seen || b_seen));
                if (rsp_valid) begin
                    check32("m_rsp_rdata", rsp_rdata, exp_rdata);
                    check1("m_rsp_err", rsp_err, exp_err);
                end
                // Handshakes that the coming rising edge will complete.
                if (!busy) begin
                    if (req_valid && req_ready) begin
                        busy = 1'b1; is_wr = req_wen;
                        m_addr = req_addr; m_wdata = req_wdata; m_wstrb = req_wstrb;
                        ar_seen = 0; r_seen = 0; aw_seen = 0; w_seen = 0; b_seen = 0;
                        if (rand_mode) predict(req_wen, req_addr, req_wdata, req_wstrb);
                        else begin exp_rdata = dir_rdata; exp_err = dir_err; end
                    end
                end else begin
                    if (rsp_valid && rsp_ready && (r_seen || b_seen)) begin
                        busy = 1'b0;
                        if (rand_mode) n_done++;
                    end
                    if (arvalid && arready) ar_seen = 1'b1;
                    if (rready  && rvalid)  r_seen  = 1'b1;
                    if (awvalid && awready) aw_seen = 1'b1;
                    if (wvalid  && wready)  w_seen  = 1'b1;
                    if (bready  && bvalid)  b_seen  = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500000 ns");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Directed sequences (cycle n = the cycle after acceptance edge n)
    // ------------------------------------------------------------------
    task automatic dir_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rr,
                            input int hold, input bit pend);
        dir_rdata = d; dir_err = (rr != 2'b00);
        @(posedge clk); #1;
        req_valid = 1; req_wen = 0; req_addr = a; req_wdata = 32'd0; req_wstrb = 4'd0;
        @(posedge clk); #1;                       // edge 0: accepted
        req_valid = 0; arready = 1;
        @(negedge clk);
        check1("rd_arvalid_c1", arvalid, 1'b1);
        check32("rd_araddr_c1", araddr, a);
        check1("rd_rsp_valid_c1", rsp_valid, 1'b0);
        @(posedge clk); #1;                       // edge 1: AR handshake
        arready = 0; rvalid = 1; rdata = d; rresp = rr;
        @(negedge clk);
        check1("rd_rready_c2", rready, 1'b1);
        check1("rd_arvalid_c2", arvalid, 1'b0);
        @(posedge clk); #1;                       // edge 2: R captured
        rvalid = 0; rdata = 32'hFFFF_FFFF; rresp = 2'b00; rsp_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check1("bp_rsp_valid", rsp_valid, 1'b1);
            check32("bp_rsp_rdata", rsp_rdata, d);
            check1("bp_req_ready", req_ready, 1'b0);
            @(posedge clk); #1;
            if (pend && i == 0) begin
                req_valid = 1; req_wen = 1; req_addr = 32'h8000_0004;
                req_wdata = 32'hCAFE_0001; req_wstrb = 4'hF;
                dir_rdata = 32'd0; dir_err = 1'b0;
            end
            if (i == hold - 1) rsp_ready = 1;
        end
        @(negedge clk);
        check1("rd_rsp_valid_c3", rsp_valid, 1'b1);
        check32("rd_rsp_rdata_c3", rsp_rdata, d);
        check1("rd_rsp_err_c3", rsp_err, rr != 2'b00);
        check1("rd_req_ready_hs", req_ready, 1'b0);
        @(posedge clk); #1;
        rsp_ready = 0;
        @(negedge clk);
        check1("rd_rsp_valid_after", rsp_valid, 1'b0);
        check1("rd_req_ready_after", req_ready, 1'b1);
    endtask

    // awready is high only in cycle ca, wready only in cycle cw.
    task automatic dir_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int ca, input int cw, input logic [1:0] br, input bit pre);
        int last;
        last = (ca > cw) ? ca : cw;
        dir_rdata = 32'd0; dir_err = (br != 2'b00);
        if (!pre) begin
            @(posedge clk); #1;
            req_valid = 1; req_wen = 1; req_addr = a; req_wdata = d; req_wstrb = s;
        end
        @(posedge clk); #1;                       // edge 0: accepted
        req_valid = 0; awready = (ca == 1); wready = (cw == 1);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            check1($sformatf("wr_awvalid_c%0d", c), awvalid, c <= ca);
            check1($sformatf("wr_wvalid_c%0d", c), wvalid, c <= cw);
            check1($sformatf("wr_bready_c%0d", c), bready, 1'b0);
            if (c == 1) begin
                check32("wr_awaddr_c1", awaddr, a);
                check32("wr_wdata_c1", wdata, d);
                check32("wr_wstrb_c1", {28'd0, wstrb}, {28'd0, s});
            end
            @(posedge clk); #1;
            awready = (c + 1 == ca); wready = (c + 1 == cw);
            if (c == last) begin bvalid = 1; bresp = br; end
        end
        @(negedge clk);
        check1("wr_bready_last", bready, 1'b1);
        check1("wr_awvalid_last", awvalid | wvalid, 1'b0);
        @(posedge clk); #1;                       // B captured
        bvalid = 0; bresp = 2'b00; rsp_ready = 1;
        @(negedge clk);
        check1("wr_rsp_valid", rsp_valid, 1'b1);
        check1("wr_rsp_err", rsp_err, br != 2'b00);
        check32("wr_rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;
        rsp_ready = 0;
        @(negedge clk);
        check1("wr_rsp_valid_after", rsp_valid, 1'b0);
        check1("wr_req_ready_after", req_ready, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    bit          acc, hs_ar, hs_r, hs_aw, hs_w, hs_b;
    bit          s_rd_pend, s_aw, s_w;
    logic [31:0] s_ar_a, s_aw_a, s_wd, s_rd_addr, s_awaddr, s_wdata;
    logic [3:0]  s_ws, s_wstrb;
    int          issued;

    initial begin : main
        rst = 0; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        rsp_ready = 0; arready = 0; rdata = 0; rresp = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'h0101_0101 * i;
            slv_mem[i] = 32'h0101_0101 * i;
        end
        #1 rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check1("reset_req_ready", req_ready, 1'b1);

        // Zero-wait read
        dir_read(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0, 1'b0);
        // AW first, W stalled to cycle 4
        dir_write(32'h8000_0020, 32'h1234_5678, 4'b0011, 1, 4, 2'b00, 1'b0);
        // W first, AW at cycle 3, SLVERR
        dir_write(32'h8000_0030, 32'hA5A5_5A5A, 4'b1111, 3, 1, 2'b10, 1'b0);
        // Response back-pressure with the next request already waiting
        dir_read(32'h8000_0014, 32'h0BAD_CAFE, 2'b11, 5, 1'b1);
        dir_write(32'h8000_0004, 32'hCAFE_0001, 4'hF, 1, 1, 2'b00, 1'b1);

        // Stray R/B valids while idle
        @(posedge clk); #1;
        rvalid = 1; rdata = 32'hFFFF_FFFF; rresp = 2'b11; bvalid = 1; bresp = 2'b11;
        repeat (3) begin
            @(negedge clk);
            check1("stray_rsp_valid", rsp_valid, 1'b0);
            check1("stray_rready", rready | bready, 1'b0);
            check1("stray_req_ready", req_ready, 1'b1);
        end
        @(posedge clk); #1;
        rvalid = 0; bvalid = 0; rresp = 0; bresp = 0;
        dir_read(32'h8000_0024, 32'h1357_9BDF, 2'b00, 0, 1'b0);

        // Reset while waiting for R
        dir_rdata = 32'h5555_AAAA; dir_err = 1'b0;
        @(posedge clk); #1;
        req_valid = 1; req_wen = 0; req_addr = 32'h8000_0040;
        @(posedge clk); #1;
        req_valid = 0; arready = 1;
        @(posedge clk); #1;
        arready = 0;
        @(negedge clk);
        check1("rstmid_rready_before", rready, 1'b1);
        #2 rst = 1;
        #1;
        check1("rstmid_arvalid", arvalid, 1'b0);
        check1("rstmid_rready", rready, 1'b0);
        check1("rstmid_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check1("rstmid_req_ready_after", req_ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check1("rstmid_no_rsp", rsp_valid, 1'b0);
        end

        // Randomised traffic against the memory-backed slave
        @(posedge clk); #1;
        rand_mode = 1'b1; issued = 0; s_rd_pend = 0; s_aw = 0; s_w = 0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(negedge clk);
            if (issued >= 300 && !req_valid && !busy) break;
            acc   = req_valid && req_ready;
            hs_ar = arvalid && arready; s_ar_a = araddr;
            hs_r  = rvalid && rready;
            hs_aw = awvalid && awready; s_aw_a = awaddr;
            hs_w  = wvalid && wready;   s_wd = wdata; s_ws = wstrb;
            hs_b  = bvalid && bready;
            @(posedge clk); #1;
            if (acc) req_valid = 0;
            if (!req_valid && issued < 300 && $urandom_range(0, 1) == 1) begin
                req_valid = 1;
                req_wen   = $urandom_range(0, 1) == 1;
                req_addr  = {24'h800000, 6'($urandom_range(0, 63)), 2'b00};
                req_wdata = $urandom;
                req_wstrb = 4'($urandom_range(0, 15));
                issued++;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            // Read side of the slave
            if (hs_ar) begin s_rd_pend = 1; s_rd_addr = s_ar_a; end
            if (hs_r) rvalid = 0;
            if (!rvalid) begin rdata = $urandom; rresp = 2'($urandom_range(0, 3)); end
            if (s_rd_pend && !rvalid && $urandom_range(0, 2) == 0) begin
                rvalid = 1; s_rd_pend = 0;
                case (s_rd_addr[7:6])
                    2'd1:    begin rresp = RESP_EXOKAY; rdata = slv_mem[s_rd_addr[5:2]]; end
                    2'd3:    begin rresp = RESP_DECERR; rdata = 32'hBADD_0000 ^ s_rd_addr; end
                    default: begin rresp = RESP_OKAY;   rdata = slv_mem[s_rd_addr[5:2]]; end
                endcase
            end
            arready = $urandom_range(0, 1) == 1;
            // Write side of the slave
            if (hs_aw) begin s_aw = 1; s_awaddr = s_aw_a; end
            if (hs_w)  begin s_w = 1; s_wdata = s_wd; s_wstrb = s_ws; end
            if (hs_b) bvalid = 0;
            if (!bvalid) bresp = 2'($urandom_range(0, 3));
            if (s_aw && s_w && !bvalid && $urandom_range(0, 2) == 0) begin
                bvalid = 1; s_aw = 0; s_w = 0;
                case (s_awaddr[7:6])
                    2'd2:    bresp = RESP_SLVERR;
                    2'd3:    bresp = RESP_DECERR;
                    default: begin
                        bresp = RESP_OKAY;
                        slv_mem[s_awaddr[5:2]] = merge(slv_mem[s_awaddr[5:2]], s_wdata, s_wstrb);
                    end
                endcase
            end
            awready = $urandom_range(0, 1) == 1;
            wready  = $urandom_range(0, 1) == 1;
        end
        check32("rand_all_done", n_done, issued);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ysyx_24110015_mem2axi
`default_nettype wire

// File: doc/ysyx_24110015_mem2axi.md
YSYX_24110015_MEM2AXI -- requirements
Module: ysyx_24110015_mem2axi

Interface
REQ-001 Parameters: none; address and data widths are fixed at 32 bits and the strobe width at 4 bits.
REQ-002 The module SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  CPU request accepted.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  CPU takes the response.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_err  out  1  1 when rresp/bresp != 2'b00.
- araddr  out  32,  arvalid  out  1,  arready  in  1  -- AR channel.
- rdata  in  32,  rresp  in  2,  rvalid  in  1,  rready  out  1  -- R channel.
- awaddr  out  32,  awvalid  out  1,  awready  in  1  -- AW channel.
- wdata  out  32,  wstrb  out  4,  wvalid  out  1,  wready  in  1  -- W channel.
- bresp  in  2,  bvalid  in  1,  bready  out  1  -- B channel.

Function
REQ-003 The block SHALL be an AXI4-Lite initiator with at most one outstanding transaction, using FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP and RSP.
REQ-004 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a clk edge where req_valid and req_ready are both 1.
REQ-005 On acceptance, the block SHALL latch addr, wdata and wstrb and enter RD_ADDR when req_wen=0, or WR_REQ when req_wen=1.
REQ-006 arvalid SHALL be 1 in RD_ADDR only, with araddr held at the latched address and stable until arready.
REQ-007 RD_ADDR SHALL go to RD_DATA on arvalid&arready.
REQ-008 rready SHALL be 1 in RD_DATA only.
REQ-009 On rvalid&rready, the block SHALL capture rdata into rsp_rdata and set rsp_err = (rresp != 0), then enter RSP.
REQ-010 On entry to WR_REQ, awvalid and wvalid SHALL both assert in the cycle after acceptance.
REQ-011 awvalid and wvalid SHALL each deassert independently after their own handshake, tracked by aw_done/w_done flags.
REQ-012 The AW and W handshakes SHALL be accepted in the same cycle or in either order.
REQ-013 awaddr, wdata and wstrb SHALL be held stable while the corresponding valid is 1.
REQ-014 WR_REQ SHALL go to WR_RESP in the cycle in which the last of the AW/W handshakes completes.
REQ-015 bready SHALL be 1 in WR_RESP only.
REQ-016 On bvalid&bready, the block SHALL set rsp_err = (bresp != 0) and rsp_rdata = 0, then enter RSP.
REQ-017 rsp_valid SHALL be 1 in RSP only, with rsp_rdata and rsp_err held stable.
REQ-018 RSP SHALL go to IDLE on rsp_valid&rsp_ready.
REQ-019 A new request SHALL NOT be accepted in the same cycle as the response handshake.
REQ-020 All AXI valid/ready outputs SHALL be driven from registered state, with no combinational path from an AXI input to an AXI output.
REQ-021 Minimum latency with zero-wait-state AXI ready/valid SHALL be: read, acceptance at cycle 0, arvalid at cycle 1, R captured at cycle 2, rsp_valid at cycle 3.
REQ-022 Minimum latency for a write SHALL be: acceptance at cycle 0, AW+W at cycle 1, B captured at cycle 2, rsp_valid at cycle 3.
REQ-023 Handshakes SHALL only be sampled in their own state; rvalid or bvalid arriving in any other state SHALL be ignored.
REQ-024 No valid signal SHALL be withdrawn before its handshake completes.

Reset
REQ-025 While rst=1, the block SHALL hold state=IDLE and drive arvalid, rready, awvalid, wvalid, bready, rsp_valid and rsp_err to 0, and rsp_rdata, araddr, awaddr, wdata and wstrb to 0, with aw_done and w_done cleared.
REQ-026 Reset asserted mid-transaction SHALL abort the transaction, dropping all valids asynchronously, with no response issued for it.
REQ-027 After reset deasserts, req_ready SHALL be 1 at the first clk edge.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding and the AXI resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10 and DECERR=2'b11.
REQ-029 The block SHALL be a single module with no sub-module.

Verification
REQ-030 Read, zero wait states: addr 0x8000_0010 with rvalid one cycle after AR, rdata 0xDEAD_BEEF, rresp 00 -> araddr=0x8000_0010, rsp_valid at cycle 3, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
REQ-031 Write, AW before W: wdata 0x1234_5678, wstrb 4'b0011, awready=1 at cycle 1, wready delayed to cycle 4 -> awvalid drops after cycle 1, wvalid holds through cycle 4, bready at cycle 5, rsp_err=0.
REQ-032 Write, W before AW: wready at cycle 1, awready at cycle 3, bresp=2'b10 -> wvalid drops after cycle 1, rsp_err=1, rsp_rdata=0.
REQ-033 Back-pressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout, next request accepted only after the rsp handshake.
REQ-034 Reset mid-read: rst asserted while in RD_DATA -> arvalid, rready and rsp_valid are 0 immediately, and req_ready=1 after release.
REQ-035 Stray rvalid=1 in IDLE with no request -> no state change and rsp_valid stays 0.
